// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first,
// through a single borrow flip-flop. Operands come in on a valid/ready
// handshake. The parallel result and its status flags go out on a second
// valid/ready handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic             bw_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             zero_q;

  logic             d_bit;
  logic             bw_d;
  logic [WIDTH-1:0] sa_d;

  // One full-subtractor bit slice on the current LSBs. The minuend
  // register doubles as the result register: each difference bit
  // enters at the MSB as the consumed minuend bit leaves at the LSB.
  always_comb begin
    d_bit = sa_q[0] ^ sb_q[0] ^ bw_q;
    bw_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bw_q);
    sa_d  = {d_bit, sa_q[WIDTH-1:1]};
  end

  // Control FSM, shift datapath and the result/flag registers.
  // On the last shift edge sa_q[0]/sb_q[0] hold the original operand MSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sa_q    <= a;
            sb_q    <= b;
            bw_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sa_q  <= sa_d;
          sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
          bw_q  <= bw_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q  <= DONE;
            diff_q   <= sa_d;
            borrow_q <= bw_d;
            zero_q   <= (sa_d == '0);
            ovf_q    <= (sa_q[0] ^ sb_q[0]) & (d_bit ^ sa_q[0]);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake and status outputs are plain decodes of the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == SHIFT);
    diff      = diff_q;
    borrow    = borrow_q;
    ovf       = ovf_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) against an
// arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         zero;
  logic         busy;

  int vectors     = 0;
  int miscompares = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: {diff, borrow, ovf, zero} from plain integer arithmetic.
  function automatic logic [6:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
    int ua, ub, sa, sb, sr;
    logic [W-1:0] dv;
    ua = int'(av);
    ub = int'(bv);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    sr = sa - sb;
    dv = W'((ua - ub + 16) % 16);
    return {dv, (ua < ub), (sr > 7 || sr < -8), (ua == ub)};
  endfunction

  // Presents one operand pair, then counts edges after the accept edge
  // until out_valid is seen (0 if it never appears). Optionally pulses
  // in_valid with different operands during SHIFT.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit pulse, output int lat);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (pulse && k == 2) begin
        in_valid = 1'b1;
        a = ~av;
        b = av ^ 4'b0101;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    vectors++;
    if ({in_ready, out_valid, busy, diff, borrow, ovf, zero} !== 10'b10_0000_0000) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b want=%b",
               {in_ready, out_valid, busy, diff, borrow, ovf, zero}, 10'b10_0000_0000);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4] = '{4'd7, 4'd3, 4'd8, 4'd5};
    logic [W-1:0] tb [4] = '{4'd3, 4'd7, 4'd1, 4'd5};
    logic [6:0]   want [4] = '{7'b0100_000, 7'b1100_100, 7'b0111_010, 7'b0000_001};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb[i], 1'b0, lat);
      vectors++;
      if (lat != int'(W)) begin
        miscompares++;
        $display("FAIL directed_latency a=%0d b=%0d got=%0d want=%0d", ta[i], tb[i], lat, W);
      end
      vectors++;
      if ({diff, borrow, ovf, zero} !== want[i]) begin
        miscompares++;
        $display("FAIL directed_result a=%0d b=%0d got=%b want=%b",
                 ta[i], tb[i], {diff, borrow, ovf, zero}, want[i]);
      end
      finish_op();
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
        miscompares++;
        $display("FAIL directed_idle got=%b want=10", {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] av, bv;
    logic [6:0]   snap;
    int lat;
    av = 4'd12; bv = 4'd3;
    start_op(av, bv, 1'b0, lat);
    snap = {diff, borrow, ovf, zero};
    vectors++;
    if (snap !== model(av, bv)) begin
      miscompares++;
      $display("FAIL bp_result got=%b want=%b", snap, model(av, bv));
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({out_valid, in_ready, diff, borrow, ovf, zero} !== {2'b10, model(av, bv)}) begin
        miscompares++;
        $display("FAIL bp_hold cycle=%0d got=%b want=%b", c,
                 {out_valid, in_ready, diff, borrow, ovf, zero}, {2'b10, model(av, bv)});
      end
    end
    in_valid = 1'b0;
    finish_op();
  endtask

  task automatic test_ignore_input();
    int lat;
    start_op(4'd6, 4'd11, 1'b1, lat);
    vectors++;
    if (lat != int'(W) || {diff, borrow, ovf, zero} !== model(4'd6, 4'd11)) begin
      miscompares++;
      $display("FAIL ignore_input lat=%0d got=%b want=%b", lat,
               {diff, borrow, ovf, zero}, model(4'd6, 4'd11));
    end
    finish_op();
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    bit seen;
    in_valid = 1'b1; a = 4'd2; b = 4'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, busy, diff, borrow, ovf, zero} !== 10'b10_0000_0000) begin
      miscompares++;
      $display("FAIL midreset_outputs got=%b want=%b",
               {in_ready, out_valid, busy, diff, borrow, ovf, zero}, 10'b10_0000_0000);
    end
    @(posedge clk); #1;
    vectors++;
    if ({in_ready, out_valid, busy, diff, borrow, ovf, zero} !== 10'b10_0000_0000) begin
      miscompares++;
      $display("FAIL midreset_held got=%b want=%b",
               {in_ready, out_valid, busy, diff, borrow, ovf, zero}, 10'b10_0000_0000);
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL midreset_no_valid got=1 want=0");
    end
    start_op(4'd9, 4'd2, 1'b0, lat);
    vectors++;
    if (lat != int'(W) || diff !== 4'd7) begin
      miscompares++;
      $display("FAIL after_reset lat=%0d diff=%0d want lat=%0d diff=7", lat, diff, W);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] av, bv;
    for (int p = 0; p < 256; p++) begin
      av = W'(p / 16);
      bv = W'(p % 16);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL sweep_in_ready a=%0d b=%0d got=%b want=1", av, bv, in_ready);
      end
      start_op(av, bv, 1'b0, lat);
      vectors++;
      if (lat != int'(W)) begin
        miscompares++;
        $display("FAIL sweep_latency a=%0d b=%0d got=%0d want=%0d", av, bv, lat, W);
      end
      vectors++;
      if ({diff, borrow, ovf, zero, in_ready} !== {model(av, bv), 1'b0}) begin
        miscompares++;
        $display("FAIL sweep_result a=%0d b=%0d got=%b want=%b", av, bv,
                 {diff, borrow, ovf, zero, in_ready}, {model(av, bv), 1'b0});
      end
      finish_op();
    end
  endtask

  task automatic test_random();
    int lat;
    int bp;
    logic [W-1:0] av, bv;
    for (int n = 0; n < 30; n++) begin
      av = W'($urandom);
      bv = W'($urandom);
      bp = int'($urandom_range(0, 3));
      start_op(av, bv, ($urandom_range(0, 1) == 1), lat);
      vectors++;
      if (lat != int'(W) || {diff, borrow, ovf, zero} !== model(av, bv)) begin
        miscompares++;
        $display("FAIL random a=%0d b=%0d lat=%0d got=%b want=%b", av, bv, lat,
                 {diff, borrow, ovf, zero}, model(av, bv));
      end
      for (int c = 0; c < bp; c++) begin
        @(posedge clk); #1;
        vectors++;
        if ({out_valid, diff, borrow, ovf, zero} !== {1'b1, model(av, bv)}) begin
          miscompares++;
          $display("FAIL random_hold a=%0d b=%0d got=%b want=%b", av, bv,
                   {out_valid, diff, borrow, ovf, zero}, {1'b1, model(av, bv)});
        end
      end
      finish_op();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_input();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing A − B one bit per clock, LSB first, through a single borrow flip-flop. It is the subtraction counterpart of the ripple-carry adder path: same operand widths, with a result that reads back as a parallel word. Operands enter on a valid/ready handshake, and the result leaves on a second valid/ready handshake. Status flags are produced alongside the result: borrow, signed overflow and zero.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands A/B valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a − b) mod 2^WIDTH
- borrow  output  1  1 iff a < b unsigned
- ovf  output  1  signed overflow: a[MSB]≠b[MSB] and diff[MSB]≠a[MSB]
- zero  output  1  diff == 0
- busy  output  1  state is SHIFT

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: latch a into shift reg SA and b into SB; clear borrow FF; set bit counter to 0; go to SHIFT.
- SHIFT: each edge processes bit 0 of SA/SB.
  - d = SA[0] ^ SB[0] ^ bw
  - bw_next = (~SA[0] & SB[0]) | (~(SA[0]^SB[0]) & bw)
  - d shifts into the MSB of the result register; SA, SB and the result register shift right by 1.
  - Counter increments each edge. On the edge where the counter reaches WIDTH−1, go to DONE.
  - Latch flags on that same edge:
    - borrow = bw_next
    - zero = (full diff == 0)
    - ovf from the stored a/b MSBs and the diff MSB
- DONE:
  - out_valid=1; diff and flags held stable.
  - On out_valid & out_ready at an edge: go to IDLE.
  - diff and flags keep their last values until the next operation's DONE.
- in_valid outside IDLE is ignored; operands are not queued.
- a and b are sampled only on the accept edge. Later changes have no effect.
- All arithmetic is modulo 2^WIDTH. There is no carry-in port; the initial borrow is always 0.

## Timing
- Reset (async assert, sync-free deassert):
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - diff=0, borrow=0, ovf=0, zero=0
- Latency:
  - Accept on edge E0.
  - SHIFT occupies edges E1..E_WIDTH.
  - out_valid rises after E_WIDTH, so it is first visible in the cycle following the WIDTH-th edge after acceptance.
- Minimum initiation interval is WIDTH+2 cycles: WIDTH shift cycles, 1 DONE cycle with out_ready=1, and 1 IDLE cycle.
- in_ready is a combinational decode of state=IDLE. It never rises in the same cycle that out_valid is high.
- Backpressure: with out_ready low, DONE holds indefinitely and outputs stay bit-stable.
- Reset mid-SHIFT or mid-DONE: the operation is abandoned. No out_valid is produced. All outputs take their reset values immediately (asynchronously).
- Simultaneous in_valid and out_ready in DONE: the result handshake completes. Operands are not accepted until the next IDLE cycle.

## Test plan
- WIDTH=4, a=7, b=3 → after 4 shift edges: out_valid=1, diff=4'b0100, borrow=0, ovf=0, zero=0.
- a=3, b=7 → diff=4'b1100, borrow=1, ovf=0; a=8, b=1 → diff=4'b0111, borrow=0, ovf=1; a=5, b=5 → diff=0, zero=1.
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles after out_valid → diff and flags unchanged, in_ready=0 throughout.
  - in_valid pulsed with new a/b during SHIFT → ignored, result still matches the first operands.
- Assert rst_n=0 on the 2nd SHIFT cycle → out_valid never rises; in_ready=1 and all outputs 0 while reset is low. A subsequent a=9, b=2 gives diff=7.
- Exhaustive sweep of all 256 (a,b) pairs back-to-back with out_ready=1:
  - diff == (a−b) mod 16
  - borrow == (a<b)
  - ovf matches signed overflow
  - zero == (a==b)
  - each result appears exactly WIDTH edges after its accept edge.
